// File: rtl/alu_muldiv_pkg.sv
// Shared op codes, FSM encodings and op-class helpers for the execute-stage ALU
// and its iterative multiply/divide unit.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'h0,
        OP_OR    = 4'h1,
        OP_ADD   = 4'h2,
        OP_SUB   = 4'h6,
        OP_SLT   = 4'h7,
        OP_MULT  = 4'h8,
        OP_MULTU = 4'h9,
        OP_DIV   = 4'hA,
        OP_DIVU  = 4'hB,
        OP_MFHI  = 4'hC,
        OP_MFLO  = 4'hD,
        OP_MTHI  = 4'hE,
        OP_MTLO  = 4'hF
    } alu_op_t;

    typedef logic [1:0] md_state_t;
    localparam md_state_t ST_IDLE = 2'd0;
    localparam md_state_t ST_RUN  = 2'd1;
    localparam md_state_t ST_FIN  = 2'd2;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Operand/result bundle between the pipeline (master) and the execute ALU (slave).
interface alu_muldiv_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             start;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (output a, b, op, start, input y, zero, ovf, busy, done);
    modport slave  (input a, b, op, start, output y, zero, ovf, busy, done);
endinterface

// File: rtl/alu_muldiv_muldiv.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// owning the architectural HI/LO registers.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
    endfunction

    md_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               accept_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     div_shl_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [WIDTH-1:0]   fin_hi_s;
    logic [WIDTH-1:0]   fin_lo_s;

    assign accept_s = start && (state_q == ST_IDLE) && (op[3] == 1'b1) &&
                      (op != OP_MFHI) && (op != OP_MFLO);

    // Multiply: {acc, multiplier} shifts right, acc gathers the multiplicand on a 1 LSB.
    assign mul_sum_s  = {1'b0, work_q[2*WIDTH-1:WIDTH]} +
                        (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next_s = {mul_sum_s, work_q[WIDTH-1:1]};

    // Divide: {rem, quotient} shifts left; a borrow in bit WIDTH means restore.
    assign div_shl_s  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    assign div_diff_s = div_shl_s - {1'b0, opnd_q};
    assign div_next_s = div_diff_s[WIDTH] ? {div_shl_s[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                          : {div_diff_s[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

    // Sign fix-up applied when the result is committed to HI/LO.
    always_comb begin
        fin_hi_s = work_q[2*WIDTH-1:WIDTH];
        fin_lo_s = work_q[WIDTH-1:0];
        if (is_div_q) begin
            if (div0_q) begin
                fin_hi_s = a_q;
                fin_lo_s = {WIDTH{1'b1}};
            end else begin
                fin_lo_s = neg_q ? (~work_q[WIDTH-1:0] + ONE_W) : work_q[WIDTH-1:0];
                fin_hi_s = neg_rem_q ? (~work_q[2*WIDTH-1:WIDTH] + ONE_W)
                                     : work_q[2*WIDTH-1:WIDTH];
            end
        end else begin
            {fin_hi_s, fin_lo_s} = neg_q ? (~work_q + ONE_2W) : work_q;
        end
    end

    // Next-state logic for the IDLE/RUN/FIN sequencer and its datapath.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        a_d       = a_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && is_muldiv(op)) begin
                    state_d   = ST_RUN;
                    cnt_d     = {CW{1'b0}};
                    work_d    = {{WIDTH{1'b0}}, mag(a, is_signed(op))};
                    opnd_d    = mag(b, is_signed(op));
                    a_d       = a;
                    is_div_d  = is_div(op);
                    neg_d     = is_signed(op) && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = is_signed(op) && a[WIDTH-1];
                    div0_d    = (b == {WIDTH{1'b0}});
                end else if (accept_s && (op == OP_MTHI)) begin
                    hi_d = a;
                end else if (accept_s && (op == OP_MTLO)) begin
                    lo_d = a;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                work_d = is_div_q ? div_next_s : mul_next_s;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIN;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_FIN: begin
                hi_d    = fin_hi_s;
                lo_d    = fin_lo_s;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation without touching HI/LO beyond clearing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CW{1'b0}};
            work_q    <= {(2*WIDTH){1'b0}};
            opnd_q    <= {WIDTH{1'b0}};
            a_q       <= {WIDTH{1'b0}};
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            opnd_q    <= opnd_d;
            a_q       <= a_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle logic/arithmetic/compare datapath plus the
// iterative multiply/divide unit and the result multiplexer.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_muldiv_if.slave  bus
);

    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] sum_s;
    logic             sub_s;
    logic             add_ovf_s;
    logic             slt_s;
    logic [WIDTH-1:0] y_s;
    logic [WIDTH-1:0] hi_s;
    logic [WIDTH-1:0] lo_s;
    logic             busy_s;
    logic             done_s;

    muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .a     (bus.a),
        .b     (bus.b),
        .op    (bus.op),
        .start (bus.start),
        .busy  (busy_s),
        .done  (done_s),
        .hi    (hi_s),
        .lo    (lo_s)
    );

    assign sub_s     = (bus.op == OP_SUB);
    assign b_eff_s   = sub_s ? ~bus.b : bus.b;
    assign sum_s     = bus.a + b_eff_s + {{(WIDTH-1){1'b0}}, sub_s};
    assign add_ovf_s = (bus.a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
    // Direct signed compare stays correct when a - b would overflow.
    assign slt_s     = ($signed(bus.a) < $signed(bus.b));

    // Result multiplexer.
    always_comb begin
        y_s = {WIDTH{1'b0}};
        case (bus.op)
            OP_AND:  y_s = bus.a & bus.b;
            OP_OR:   y_s = bus.a | bus.b;
            OP_ADD:  y_s = sum_s;
            OP_SUB:  y_s = sum_s;
            OP_SLT:  y_s = {{(WIDTH-1){1'b0}}, slt_s};
            OP_MFHI: y_s = hi_s;
            OP_MFLO: y_s = lo_s;
            default: y_s = {WIDTH{1'b0}};
        endcase
    end

    assign bus.y    = y_s;
    assign bus.zero = (y_s == {WIDTH{1'b0}});
    assign bus.ovf  = ((bus.op == OP_ADD) || (bus.op == OP_SUB)) ? add_ovf_s : 1'b0;
    assign bus.busy = busy_s;
    assign bus.done = done_s;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv at WIDTH=32 with a queue-based HI/LO scoreboard.
module tb_alu_muldiv;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] cur_lo = 32'h0;

    alu_muldiv_if #(.WIDTH(32)) bus ();

    alu_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            OP_MULT:  begin q = sa * sb; return q; end
            OP_MULTU: return ua * ub;
            OP_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        exp_q.push_back(exp);
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int nbusy);
        bit seen = 1'b0;
        logic [63:0] exp;
        nbusy = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.done) seen = 1'b1;
            else begin
                if (bus.busy) nbusy++;
                step();
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout: done=%0b required 1 within 40 cycles", name, bus.done);
        end
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard: queue size 0 required >0", name);
        end else begin
            exp = exp_q.pop_front();
            if (seen) begin
                bus.op = OP_MFHI;
                #1;
                checks++;
                if (bus.y !== exp[63:32]) begin
                    failures++;
                    $display("FAIL %s_hi: got %h required %h", name, bus.y, exp[63:32]);
                end
                bus.op = OP_MFLO;
                #1;
                checks++;
                if (bus.y !== exp[31:0]) begin
                    failures++;
                    $display("FAIL %s_lo: got %h required %h", name, bus.y, exp[31:0]);
                end
                checks++;
                if (bus.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_busy_at_done: got %b required 0", name, bus.busy);
                end
            end
            cur_lo = exp[31:0];
        end
    endtask

    task automatic test_reset();
        bus.op = OP_AND; bus.a = 32'h0; bus.b = 32'h0; bus.start = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        bus.op = OP_MFHI; #1;
        checks++;
        if (bus.y !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h required 0", bus.y); end
        bus.op = OP_MFLO; #1;
        checks++;
        if (bus.y !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h required 0", bus.y); end
    endtask

    typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] y; logic ovf; } vec_t;

    task automatic test_alu();
        vec_t v[15];
        v = '{
            '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1},
            '{OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0},
            '{OP_ADD, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0},
            '{OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1},
            '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
            '{OP_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b1},
            '{OP_AND, 32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 1'b0},
            '{OP_OR,  32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0},
            '{4'h3,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
            '{4'h5,   32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
            '{OP_SLT, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0},
            '{OP_SLT, 32'h00000001, 32'h80000000, 32'h00000000, 1'b0},
            '{OP_SLT, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0},
            '{OP_SLT, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0},
            '{OP_MULT, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b0}
        };
        bus.start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            bus.op = v[i].op; bus.a = v[i].a; bus.b = v[i].b;
            #1;
            checks++;
            if (bus.y !== v[i].y) begin
                failures++;
                $display("FAIL alu_y[%0d]: got %h required %h", i, bus.y, v[i].y);
            end
            checks++;
            if (bus.ovf !== v[i].ovf) begin
                failures++;
                $display("FAIL alu_ovf[%0d]: got %b required %b", i, bus.ovf, v[i].ovf);
            end
            checks++;
            if (bus.zero !== (v[i].y == 32'h0)) begin
                failures++;
                $display("FAIL alu_zero[%0d]: got %b required %b", i, bus.zero, (v[i].y == 32'h0));
            end
        end
        step();
    endtask

    task automatic test_mult();
        int n;
        launch(OP_MULT, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB);
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL mult_accept: busy=%b required 1", bus.busy); end
        wait_done("mult", n);
        checks++;
        if (n != 33) begin failures++; $display("FAIL mult_latency: busy cycles %0d required 33", n); end
        step();
        checks++;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse: done=%b required 0", bus.done); end
        launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        wait_done("multu", n);
        step();
    endtask

    task automatic test_div();
        int n;
        launch(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
        wait_done("div_neg", n);
        launch(OP_DIVU, 32'h00000007, 32'h00000000, 64'h00000007_FFFFFFFF);
        wait_done("divu_by0", n);
        checks++;
        if (n != 33) begin failures++; $display("FAIL div0_latency: busy cycles %0d required 33", n); end
        launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        wait_done("div_minneg", n);
        launch(OP_DIV, 32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF);
        wait_done("div_by0", n);
        step();
    endtask

    task automatic test_mt_hazard();
        int n;
        bus.op = OP_MTHI; bus.a = 32'h00001234; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL mthi_flags: busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        bus.op = OP_MFHI; #1;
        checks++;
        if (bus.y !== 32'h00001234) begin failures++; $display("FAIL mthi_value: got %h required 00001234", bus.y); end
        launch(OP_MULT, 32'h00000005, 32'h00000006, 64'h00000000_0000001E);
        step(); step(); step();
        bus.op = OP_MTLO; bus.a = 32'h0000DEAD; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.a = 32'hAAAA5555; bus.b = 32'h00000000;
        bus.op = OP_MFHI; #1;
        checks++;
        if (bus.y !== 32'h00001234) begin failures++; $display("FAIL mfhi_busy: got %h required 00001234", bus.y); end
        bus.op = OP_MFLO; #1;
        checks++;
        if (bus.y !== cur_lo) begin failures++; $display("FAIL mflo_busy: got %h required %h", bus.y, cur_lo); end
        wait_done("mult_after_mthi", n);
        launch(OP_DIVU, 32'h00000064, 32'h00000007, 64'h00000002_0000000E);
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: busy=%b required 1", bus.busy); end
        wait_done("divu_b2b", n);
    endtask

    task automatic test_random();
        int n;
        logic [3:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            op = 4'h8 + 4'($urandom_range(0, 3));
            a = $urandom();
            b = (i == 2) ? 32'h0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom());
            launch(op, a, b, model(op, a, b));
            wait_done("random", n);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        bus.op = OP_MULT; bus.a = 32'h00000003; bus.b = 32'h00000004; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_flags: busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        bus.op = OP_MFHI; #1;
        checks++;
        if (bus.y !== 32'h0) begin failures++; $display("FAIL reset_mid_hi: got %h required 0", bus.y); end
        bus.op = OP_MFLO; #1;
        checks++;
        if (bus.y !== 32'h0) begin failures++; $display("FAIL reset_mid_lo: got %h required 0", bus.y); end
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen = 1'b1;
            step();
        end
        checks++;
        if (seen) begin failures++; $display("FAIL reset_mid_no_done: done seen=1 required 0"); end
        reset = 1'b1; bus.op = OP_DIVU; bus.a = 32'h9; bus.b = 32'h3; bus.start = 1'b1;
        step();
        reset = 1'b0; bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_wins: busy=%b required 0", bus.busy); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain: size %0d required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mult();
        test_div();
        test_mt_hazard();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
